hwpf_stride_wrr_arb: RTL

Second-generation request arbiter for the stride hardware-prefetcher cluster. It sits between up to 16 prefetch engines and the single HPDcache request port. It grants engines with per-engine weighted round-robin and limits each engine's outstanding responses with a counter. It registers the winning request, rewrites its transaction ID with the engine index, and routes cache responses back to the owning engine by that ID.

---
 rtl/hwpf_stride_wrr_arb.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/hwpf_stride_wrr_arb.sv
// Weighted round-robin request arbiter for the stride prefetcher cluster.
// Registers the winning request, tags it with the engine index and routes responses back by that tag.
package hwpf_stride_wrr_arb_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  tid;
    logic        need_rsp;
  } hpdcache_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  tid;
  } hpdcache_rsp_t;
endpackage

module hwpf_stride_wrr_arb #(
  parameter int unsigned NUM_HW_PREFETCH = 4,
  parameter int unsigned MAX_INFLIGHT    = 2,
  parameter int unsigned WEIGHT_WIDTH    = 3,
  parameter type hpdcache_req_t = hwpf_stride_wrr_arb_pkg::hpdcache_req_t,
  parameter type hpdcache_rsp_t = hwpf_stride_wrr_arb_pkg::hpdcache_rsp_t,
  localparam int unsigned IDX_W = (NUM_HW_PREFETCH > 1) ? $clog2(NUM_HW_PREFETCH) : 1,
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic [NUM_HW_PREFETCH-1:0][WEIGHT_WIDTH-1:0]  weight_i,
  input  logic [NUM_HW_PREFETCH-1:0]                    eng_req_valid_i,
  output logic [NUM_HW_PREFETCH-1:0]                    eng_req_ready_o,
  input  hpdcache_req_t [NUM_HW_PREFETCH-1:0]           eng_req_i,
  output logic [NUM_HW_PREFETCH-1:0]                    eng_rsp_valid_o,
  output hpdcache_rsp_t [NUM_HW_PREFETCH-1:0]           eng_rsp_o,
  output logic [NUM_HW_PREFETCH-1:0][CNT_W-1:0]         inflight_o,
  output logic                                          hpdcache_req_valid_o,
  input  logic                                          hpdcache_req_ready_i,
  output hpdcache_req_t                                 hpdcache_req_o,
  input  logic                                          hpdcache_rsp_valid_i,
  input  hpdcache_rsp_t                                 hpdcache_rsp_i,
  output logic                                          rsp_err_o
);

  if (NUM_HW_PREFETCH < 1 || NUM_HW_PREFETCH > 16) begin : g_bad_num
    $fatal(1, "hwpf_stride_wrr_arb: NUM_HW_PREFETCH must be 1..16");
  end
  if (MAX_INFLIGHT < 1 || MAX_INFLIGHT > 15) begin : g_bad_inflight
    $fatal(1, "hwpf_stride_wrr_arb: MAX_INFLIGHT must be 1..15");
  end

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  logic                                      out_valid_q;
  hpdcache_req_t                             out_req_q;
  logic [IDX_W-1:0]                          ptr_q;
  logic [WEIGHT_WIDTH-1:0]                   cnt_q;
  logic [NUM_HW_PREFETCH-1:0][CNT_W-1:0]     inflight_q, inflight_d;
  logic                                      rsp_err_q;

  logic [NUM_HW_PREFETCH-1:0]                eligible;
  logic [NUM_HW_PREFETCH-1:0][WEIGHT_WIDTH-1:0] eff_w;
  logic                                      load;
  logic                                      stay;
  logic                                      adv_found;
  logic [IDX_W-1:0]                          adv_idx;
  logic [IDX_W-1:0]                          cand;
  logic                                      gnt_any;
  logic [IDX_W-1:0]                          gnt_idx;
  hpdcache_req_t                             req_mod;
  logic [IDX_W-1:0]                          rsp_idx;
  logic                                      rsp_upper_zero;
  logic [NUM_HW_PREFETCH-1:0]                rsp_hit;

  assign load = !out_valid_q || hpdcache_req_ready_i;

  always_comb begin
    eligible = '0;
    eff_w    = '0;
    for (int unsigned i = 0; i < NUM_HW_PREFETCH; i++) begin
      eff_w[i]    = (weight_i[i] == '0) ? WEIGHT_WIDTH'(1) : weight_i[i];
      eligible[i] = eng_req_valid_i[i] && (!eng_req_i[i].need_rsp || inflight_q[i] < MAX_CNT);
    end
  end

  // Advance scan starts after ptr and wraps back to ptr itself as the last candidate.
  always_comb begin
    stay      = eligible[ptr_q] && (cnt_q < eff_w[ptr_q]);
    adv_found = 1'b0;
    adv_idx   = ptr_q;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_HW_PREFETCH; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % NUM_HW_PREFETCH);
      if (!adv_found && eligible[cand]) begin
        adv_found = 1'b1;
        adv_idx   = cand;
      end
    end
    gnt_any = load && (stay || adv_found);
    gnt_idx = stay ? ptr_q : adv_idx;
  end

  always_comb begin
    eng_req_ready_o = '0;
    if (gnt_any) eng_req_ready_o[gnt_idx] = 1'b1;
    req_mod                 = eng_req_i[gnt_idx];
    req_mod.tid             = '0;
    req_mod.tid[IDX_W-1:0]  = gnt_idx;
  end

  // Index match against each engine also rejects idx >= N without an out-of-range select.
  always_comb begin
    rsp_idx        = hpdcache_rsp_i.tid[IDX_W-1:0];
    rsp_upper_zero = ((hpdcache_rsp_i.tid >> IDX_W) == '0);
    rsp_hit        = '0;
    for (int unsigned i = 0; i < NUM_HW_PREFETCH; i++) begin
      if (hpdcache_rsp_valid_i && rsp_upper_zero && rsp_idx == IDX_W'(i) && inflight_q[i] != '0)
        rsp_hit[i] = 1'b1;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    for (int unsigned i = 0; i < NUM_HW_PREFETCH; i++) begin
      logic inc;
      inc = gnt_any && gnt_idx == IDX_W'(i) && eng_req_i[i].need_rsp;
      if (inc && !rsp_hit[i])      inflight_d[i] = inflight_q[i] + CNT_W'(1);
      else if (!inc && rsp_hit[i]) inflight_d[i] = inflight_q[i] - CNT_W'(1);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_HW_PREFETCH; i++) eng_rsp_o[i] = hpdcache_rsp_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_req_q   <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      inflight_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (load) begin
        out_valid_q <= gnt_any;
        if (gnt_any) begin
          out_req_q <= req_mod;
          if (stay) begin
            cnt_q <= cnt_q + WEIGHT_WIDTH'(1);
          end else begin
            ptr_q <= adv_idx;
            cnt_q <= WEIGHT_WIDTH'(1);
          end
        end
      end
      inflight_q <= inflight_d;
      rsp_err_q  <= hpdcache_rsp_valid_i && (rsp_hit == '0);
    end
  end

  assign eng_rsp_valid_o      = rsp_hit;
  assign inflight_o           = inflight_q;
  assign hpdcache_req_valid_o = out_valid_q;
  assign hpdcache_req_o       = out_req_q;
  assign rsp_err_o            = rsp_err_q;

endmodule
